// File: rtl/aes_capture_buffer_if.sv
// Request handshake, AES-core, and read-port signals of aes_capture_buffer.
// "master" is the environment side and "slave" is the capture buffer.
interface aes_capture_buffer_if #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 16
);
  logic                     in_valid;
  logic [DATA_W-1:0]        in_state;
  logic [DATA_W-1:0]        in_key;
  logic                     in_ready;
  logic [DATA_W-1:0]        aes_state;
  logic [DATA_W-1:0]        aes_key;
  logic [DATA_W-1:0]        aes_out;
  logic                     mode;
  logic                     rd_en;
  logic [DATA_W-1:0]        rd_data;
  logic                     rd_valid;
  logic [$clog2(DEPTH):0]   count;
  logic                     empty;
  logic                     full;
  logic [15:0]              drop_cnt;

  modport master (
    output in_valid, in_state, in_key, aes_out, mode, rd_en,
    input  in_ready, aes_state, aes_key, rd_data, rd_valid, count, empty, full, drop_cnt
  );

  modport slave (
    input  in_valid, in_state, in_key, aes_out, mode, rd_en,
    output in_ready, aes_state, aes_key, rd_data, rd_valid, count, empty, full, drop_cnt
  );
endinterface

// File: rtl/aes_capture_buffer.sv
// Capture stage for a fixed-latency AES-128 core: a tag pipeline tracks requests, and results go into a DEPTH-word ring buffer.
// Optional feature macro: AES_CAPTURE_DROP_CNT_EN enables the saturating lost-result counter on drop_cnt.
module aes_capture_buffer #(
  parameter int DATA_W      = 128,
  parameter int DEPTH       = 16,
  parameter int AES_LATENCY = 21
) (
  input logic                 clk,
  input logic                 rst,
  aes_capture_buffer_if.slave io_bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_N = AES_LATENCY + 1;
  localparam int INF_W = $clog2(TAG_N + 1);
  localparam int SUM_W = $clog2(DEPTH + TAG_N + 1) + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_aes_state;
  logic [DATA_W-1:0] r_aes_key;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic [TAG_N-1:0]  r_tag;
  logic [INF_W-1:0]  r_inflight;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_ready;
  logic              w_accept;
  logic              w_write;
  logic              w_full;
  logic              w_pop;
  logic              w_store;
  logic              w_overwrite;
  logic [SUM_W-1:0]  w_used;

  // NOTE: credit uses only registered count/inflight, so in_ready has no path from in_valid or rd_en.
  assign w_used   = SUM_W'(r_count) + SUM_W'(r_inflight);
  assign w_ready  = io_bus.mode || (w_used < SUM_W'(DEPTH));
  assign w_accept = io_bus.in_valid && w_ready;

  assign w_write     = r_tag[TAG_N-1];
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_pop       = io_bus.rd_en && (r_count != '0);
  assign w_store     = w_write && (!w_full || w_pop || io_bus.mode);
  assign w_overwrite = w_write && w_full && !w_pop && io_bus.mode;

  // Request side: core operand registers and the tag pipeline that mirrors the core latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aes_state <= '0;
      r_aes_key   <= '0;
      r_tag       <= '0;
      r_inflight  <= '0;
    end else begin
      if (w_accept) begin
        r_aes_state <= io_bus.in_state;
        r_aes_key   <= io_bus.in_key;
      end
      r_tag      <= {r_tag[TAG_N-2:0], w_accept};
      r_inflight <= r_inflight + INF_W'(w_accept) - INF_W'(w_write);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop) r_rd_data <= r_mem[r_rd_ptr];
      if (w_store) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop || w_overwrite) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_store && !w_overwrite) - CNT_W'(w_pop);
    end
  end

  // NOTE: storage is deliberately not reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_store && !rst) r_mem[r_wr_ptr] <= io_bus.aes_out;
  end

`ifdef AES_CAPTURE_DROP_CNT_EN
  logic        w_drop;
  logic [15:0] r_drop_cnt;

  assign w_drop = w_write && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign io_bus.drop_cnt = r_drop_cnt;
`else
  assign io_bus.drop_cnt = '0;
`endif

  assign io_bus.in_ready  = w_ready;
  assign io_bus.aes_state = r_aes_state;
  assign io_bus.aes_key   = r_aes_key;
  assign io_bus.rd_data   = r_rd_data;
  assign io_bus.rd_valid  = r_rd_valid;
  assign io_bus.count     = r_count;
  assign io_bus.empty     = (r_count == '0);
  assign io_bus.full      = w_full;
endmodule

// File: tb/tb_aes_capture_buffer.sv
// Directed bench: a golden-vector AES core model drives a DEPTH=16 instance, and a delay-line stub drives a DEPTH=4 instance.
module tb_aes_capture_buffer;
  localparam int LAT_A = 21;
  localparam int LAT_B = 4;

  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;

`ifdef AES_CAPTURE_DROP_CNT_EN
  localparam int EXP_DROP = 2;
`else
  localparam int EXP_DROP = 0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   n_acc;

  aes_capture_buffer_if #(.DATA_W(128), .DEPTH(16)) bus_a ();
  aes_capture_buffer_if #(.DATA_W(128), .DEPTH(4))  bus_b ();

  aes_capture_buffer #(.DATA_W(128), .DEPTH(16), .AES_LATENCY(LAT_A)) u_dut_a (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus_a.slave)
  );

  aes_capture_buffer #(.DATA_W(128), .DEPTH(4), .AES_LATENCY(LAT_B)) u_dut_b (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model that knows the two reference vectors; anything else maps to state^key.
  function automatic logic [127:0] golden(input logic [127:0] st, input logic [127:0] ky);
    if (st == PT1 && ky == K1) return CT1;
    if (st == PT2 && ky == K2) return CT2;
    return st ^ ky;
  endfunction

  logic [127:0] pipe_a [LAT_A];
  logic [127:0] pipe_b [LAT_B];

  always @(posedge clk) begin
    pipe_a[0] <= golden(bus_a.aes_state, bus_a.aes_key);
    for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
    pipe_b[0] <= bus_b.aes_state;
    for (int j = 1; j < LAT_B; j++) pipe_b[j] <= pipe_b[j-1];
  end

  assign bus_a.aes_out = pipe_a[LAT_A-1];
  assign bus_b.aes_out = pipe_b[LAT_B-1];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [127:0] exp_pop [4];
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_state = '0; bus_a.in_key = '0;
    bus_a.mode = 1'b0;     bus_a.rd_en = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_state = '0; bus_b.in_key = '0;
    bus_b.mode = 1'b0;     bus_b.rd_en = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_count",    128'(bus_a.count),    128'd0);
    check("rst_empty",    128'(bus_a.empty),    128'd1);
    check("rst_full",     128'(bus_a.full),     128'd0);
    check("rst_rd_valid", 128'(bus_a.rd_valid), 128'd0);
    check("rst_rd_data",  bus_a.rd_data,        128'd0);
    check("rst_aes_state", bus_a.aes_state,     128'd0);
    check("rst_drop",     128'(bus_a.drop_cnt), 128'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 128'(bus_a.in_ready), 128'd1);

    // Single request, exact capture latency, then one pop
    bus_a.in_valid = 1'b1; bus_a.in_state = PT1; bus_a.in_key = K1;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    check("a1_aes_state", bus_a.aes_state, PT1);
    check("a1_aes_key",   bus_a.aes_key,   K1);
    repeat (LAT_A) @(negedge clk);
    check("a1_count_early", 128'(bus_a.count), 128'd0);
    @(negedge clk);
    check("a1_count_cap", 128'(bus_a.count), 128'd1);
    check("a1_not_empty", 128'(bus_a.empty), 128'd0);
    bus_a.rd_en = 1'b1;
    @(negedge clk);
    bus_a.rd_en = 1'b0;
    check("a1_rd_valid", 128'(bus_a.rd_valid), 128'd1);
    check("a1_rd_data",  bus_a.rd_data,        CT1);
    check("a1_count0",   128'(bus_a.count),    128'd0);
    @(negedge clk);
    check("a1_rd_valid_pulse", 128'(bus_a.rd_valid), 128'd0);
    check("a1_rd_data_hold",   bus_a.rd_data,        CT1);

    // Pop from empty is ignored
    bus_a.rd_en = 1'b1;
    @(negedge clk);
    bus_a.rd_en = 1'b0;
    check("a1_empty_pop_valid", 128'(bus_a.rd_valid), 128'd0);
    check("a1_empty_pop_data",  bus_a.rd_data,        CT1);
    check("a1_empty_pop_count", 128'(bus_a.count),    128'd0);

    // Back-to-back requests, in-order pops
    bus_a.in_valid = 1'b1; bus_a.in_state = PT1; bus_a.in_key = K1;
    @(negedge clk);
    bus_a.in_state = PT2; bus_a.in_key = K2;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    repeat (LAT_A + 2) @(negedge clk);
    check("a2_count2", 128'(bus_a.count), 128'd2);
    bus_a.rd_en = 1'b1;
    @(negedge clk);
    check("a2_pop1_valid", 128'(bus_a.rd_valid), 128'd1);
    check("a2_pop1_data",  bus_a.rd_data,        CT1);
    @(negedge clk);
    bus_a.rd_en = 1'b0;
    check("a2_pop2_valid", 128'(bus_a.rd_valid), 128'd1);
    check("a2_pop2_data",  bus_a.rd_data,        CT2);
    check("a2_empty",      128'(bus_a.empty),    128'd1);

    // Stub, DEPTH=4, mode 0: in_valid held high, credit limits accepts to 4
    n_acc = 0;
    bus_b.in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus_b.in_state = 128'hA0 + 128'(n_acc);
      if (bus_b.in_ready) n_acc++;
      @(negedge clk);
    end
    bus_b.in_valid = 1'b0;
    check("b3_accepts",  128'(n_acc),           128'd4);
    check("b3_in_ready", 128'(bus_b.in_ready),  128'd0);
    check("b3_count",    128'(bus_b.count),     128'd4);
    check("b3_full",     128'(bus_b.full),      128'd1);
    check("b3_drop",     128'(bus_b.drop_cnt),  128'd0);
    for (int i = 0; i < 4; i++) begin
      bus_b.rd_en = 1'b1;
      @(negedge clk);
      bus_b.rd_en = 1'b0;
      check("b3_pop_data", bus_b.rd_data, 128'hA0 + 128'(i));
    end
    check("b3_empty",        128'(bus_b.empty),    128'd1);
    check("b3_ready_again",  128'(bus_b.in_ready), 128'd1);

    // Stub, mode 1: six results into four slots overwrite the two oldest
    bus_b.mode = 1'b1;
    bus_b.in_valid = 1'b1;
    for (int v = 1; v <= 6; v++) begin
      bus_b.in_state = 128'(v);
      @(negedge clk);
    end
    bus_b.in_valid = 1'b0;
    repeat (LAT_B + 3) @(negedge clk);
    check("b4_count", 128'(bus_b.count),    128'd4);
    check("b4_full",  128'(bus_b.full),     128'd1);
    check("b4_drop",  128'(bus_b.drop_cnt), 128'(EXP_DROP));

    // Full buffer: capture of 7 coincides with a pop
    bus_b.in_valid = 1'b1; bus_b.in_state = 128'd7;
    @(negedge clk);
    bus_b.in_valid = 1'b0;
    repeat (LAT_B) @(negedge clk);
    bus_b.rd_en = 1'b1;
    @(negedge clk);
    bus_b.rd_en = 1'b0;
    check("b5_pop_valid", 128'(bus_b.rd_valid), 128'd1);
    check("b5_pop_data",  bus_b.rd_data,        128'd3);
    check("b5_count",     128'(bus_b.count),    128'd4);
    check("b5_drop",      128'(bus_b.drop_cnt), 128'(EXP_DROP));
    exp_pop[0] = 128'd4; exp_pop[1] = 128'd5; exp_pop[2] = 128'd6; exp_pop[3] = 128'd7;
    for (int i = 0; i < 4; i++) begin
      bus_b.rd_en = 1'b1;
      @(negedge clk);
      bus_b.rd_en = 1'b0;
      check("b5_drain_data", bus_b.rd_data, exp_pop[i]);
    end
    check("b5_drained_empty", 128'(bus_b.empty), 128'd1);

    // Reset with three requests in flight: none of them may ever be captured
    bus_b.in_valid = 1'b1;
    for (int v = 8; v <= 10; v++) begin
      bus_b.in_state = 128'(v);
      @(negedge clk);
    end
    bus_b.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("b6_count_rst",  128'(bus_b.count),    128'd0);
    check("b6_ready_rst",  128'(bus_b.in_ready), 128'd1);
    repeat (LAT_B + 4) @(negedge clk);
    check("b6_count_late", 128'(bus_b.count),    128'd0);
    check("b6_empty_late", 128'(bus_b.empty),    128'd1);
    check("b6_rd_valid",   128'(bus_b.rd_valid), 128'd0);
    check("b6_drop",       128'(bus_b.drop_cnt), 128'd0);
    check("b6_aes_state",  bus_b.aes_state,      128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_capture_buffer.md
# aes_capture_buffer

Parametrised capture stage between a fixed-latency pipelined AES-128 core and the rest of the design. Accepts state/key requests on a valid/ready handshake, drives them into the core, tracks each request through the core's pipeline, and stores the resulting ciphertexts in a DEPTH-word circular buffer. The buffer is drained through a registered read port. It supersedes the single-word always-write capture RAM with:
- multi-word storage,
- flow control,
- a selectable stop-when-full or overwrite-oldest mode.

## Interface
- DATA_W, 128, state/key/ciphertext width
- DEPTH, 16, buffer words; power of two, ≥2
- AES_LATENCY, 21, cycles from core input change to matching core output
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  request present
- in_state  in  DATA_W  plaintext
- in_key  in  DATA_W  key
- in_ready  out  1  request accepted on edge where in_valid && in_ready
- aes_state  out  DATA_W  registered state to core
- aes_key  out  DATA_W  registered key to core
- aes_out  in  DATA_W  core ciphertext
- mode  in  1  0 = stop-when-full, 1 = overwrite-oldest
- rd_en  in  1  pop request
- rd_data  out  DATA_W  popped word, registered
- rd_valid  out  1  rd_data valid this cycle, one-cycle pulse
- count  out  $clog2(DEPTH)+1  stored words, 0..DEPTH
- empty, full  out  1  count==0, count==DEPTH
- drop_cnt  out  16  results lost to overwrite/drop (see Configuration)

## Operation
- Accept: aes_state/aes_key load in_state/in_key. A tag bit enters a tag shift register of length AES_LATENCY+1.
- No accept: aes_state/aes_key hold. The tag enters 0.
- Tag reaching the last stage writes aes_out into mem[wr_ptr]. This is AES_LATENCY+1 edges after the accepting edge.
- inflight = number of set tags, 0..AES_LATENCY+1.
- in_ready, mode 0: (count + inflight) < DEPTH. Credit counts words already popped this cycle only from the next cycle.
- in_ready, mode 1: 1.
- Write when not full: mem[wr_ptr] written; wr_ptr+1; count+1.
- Write when full, mode 1: oldest word overwritten; wr_ptr+1; rd_ptr+1; count stays DEPTH; drop_cnt+1.
- Write when full, mode 0: result discarded; drop_cnt+1. Occurs only if mode switched 1→0 with excess work in flight.
- Pop when rd_en && !empty: rd_data <= mem[rd_ptr] (value before any same-edge write); rd_ptr+1; count-1; rd_valid=1 next cycle.
- rd_en && empty: ignored. rd_valid=0, rd_data holds.
- Write and pop on the same edge, not full: count unchanged.
- Write and pop on the same edge, full: the pop returns the old word and the write lands in the freed slot. Both pointers +1; count stays DEPTH; no drop.
- Pointers wrap modulo DEPTH.
- mode is sampled every cycle; no other state depends on its history.

## Timing
- Reset (rst=1 on an edge) sets:
  - aes_state, aes_key, rd_data = 0
  - all tags = 0
  - wr_ptr, rd_ptr, count, drop_cnt = 0
  - rd_valid = 0; empty = 1; full = 0
  - in_ready = 1 from the first cycle after reset
- Mem contents are not reset.
- Reset mid-operation flushes all tags. Core outputs belonging to pre-reset requests are never written.
- Request-to-capture latency: AES_LATENCY+1 cycles. Capture-to-visible in count/empty: same edge.
- Pop latency: 1 cycle (rd_en edge → rd_valid/rd_data next cycle).
- Throughput: one accept per cycle while in_ready=1.
- count, full, empty, in_ready are registered or derived from registered state only. There is no combinational path from in_valid or rd_en.

## Configuration
- AES_CAPTURE_DROP_CNT_EN defined: drop_cnt is a 16-bit counter incremented per lost result, saturating at 0xFFFF, cleared only by rst.
- Undefined: counter logic absent; drop_cnt tied to 0. All other behaviour is identical.

## Test plan
- Real core, DEPTH=16. Request state 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f. Expect count=1 exactly AES_LATENCY+1 cycles after accept; pop → rd_data=69c4e0d86a7b0430d8cdb78070b4c55a, rd_valid one cycle.
- Real core, back-to-back requests: that vector, then state 3243f6a8885a308d313198a2e0370734 with key 2b7e151628aed2a6abf7158809cf4f3c. Pops return 69c4…c55a then 3925841d02dc09fbdc118597196a0b32, in order.
- Delay-line stub core, DEPTH=4, mode 0, in_valid held high, no pops. Exactly 4 accepts, then in_ready=0; count settles at 4; drop_cnt=0.
- Stub, DEPTH=4, mode 1, 6 requests tagged 1..6, no pops. count=4, drop_cnt=2 (with macro); pops return 3,4,5,6.
- Full buffer, mode 1, write and rd_en on the same edge. rd_data = oldest word; count stays 4; drop_cnt unchanged. Then assert rst mid-stream with 3 in flight: count=0, no writes ever appear, empty=1.
